// File: rtl/addr_counter_defs.sv
// Shared constants for the cascadable address counter (nibble width, terminal values).
// REG_DELAY defaults to empty so synthesis sees a plain register assignment.
`ifndef REG_DELAY
`define REG_DELAY
`endif

package addr_counter_defs;

    localparam int NIBBLE_W = 4;

    localparam logic [NIBBLE_W-1:0] NIB_TERM_UP = 4'hF;
    localparam logic [NIBBLE_W-1:0] NIB_TERM_DN = 4'h0;

    // A nibble passes the carry on when it sits at the value that wraps on the next count.
    function automatic logic [NIBBLE_W-1:0] nib_term(input logic up);
        return up ? NIB_TERM_UP : NIB_TERM_DN;
    endfunction

endpackage

// File: rtl/addr_counter_nibble.sv
// One 4-bit slice of the address counter: clear/load/count register plus carry chain link.
`ifndef REG_DELAY
`define REG_DELAY
`endif

module addr_counter_nibble
    import addr_counter_defs::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_i,
    input  logic                load_i,
    input  logic                cnt_i,
    input  logic                up_i,
    input  logic                carry_i,
    input  logic [NIBBLE_W-1:0] d_i,
    output logic [NIBBLE_W-1:0] q_o,
    output logic                carry_o
);

    logic [NIBBLE_W-1:0] q_q;
    logic [NIBBLE_W-1:0] q_d;

    // clr/load/cnt arrive already mutually exclusive from the top-level decode.
    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (load_i) begin
            q_d = d_i;
        end else if (cnt_i && carry_i) begin
            q_d = up_i ? (q_q + 4'd1) : (q_q - 4'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= `REG_DELAY q_d;
        end
    end

    assign q_o     = q_q;
    assign carry_o = carry_i & (q_q == nib_term(up_i));

endmodule

// File: rtl/addr_counter_stage.sv
// Cascadable 74S163-style binary address counter feeding the 74S157 A inputs.
// Define ADDR_COUNTER_UPDOWN_EN to add the U_D port and down counting.
module addr_counter_stage
    import addr_counter_defs::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic                         CLK,
    input  logic                         CLR_N,
    input  logic                         SCLR_N,
    input  logic                         LOAD_N,
    input  logic                         ENP,
    input  logic                         ENT,
`ifdef ADDR_COUNTER_UPDOWN_EN
    input  logic                         U_D,
`endif
    input  logic [WIDTH-1:0]             D,
    output logic [WIDTH-1:0]             Q,
    output logic [WIDTH/NIBBLE_W-1:0]    NIB_CO,
    output logic                         RCO
);

    localparam int NIB = WIDTH / NIBBLE_W;

    logic         up;
    logic         clr_act;
    logic         load_act;
    logic         cnt_act;
    logic [NIB:0] carry;

`ifdef ADDR_COUNTER_UPDOWN_EN
    assign up = U_D;
`else
    assign up = 1'b1;
`endif

    assign clr_act  = ~SCLR_N;
    assign load_act = SCLR_N & ~LOAD_N;
    assign cnt_act  = SCLR_N & LOAD_N & ENP;

    // ENT seeds the chain, so each nibble counts only when every lower nibble is terminal.
    assign carry[0] = ENT;

    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            addr_counter_nibble u_nib (
                .clk     (CLK),
                .rst_n   (CLR_N),
                .clr_i   (clr_act),
                .load_i  (load_act),
                .cnt_i   (cnt_act),
                .up_i    (up),
                .carry_i (carry[gi]),
                .d_i     (D[gi*NIBBLE_W +: NIBBLE_W]),
                .q_o     (Q[gi*NIBBLE_W +: NIBBLE_W]),
                .carry_o (carry[gi+1])
            );
            assign NIB_CO[gi] = carry[gi+1];
        end
    endgenerate

    assign RCO = carry[NIB];

endmodule

// File: tb/tb_addr_counter_stage.sv
// Self-checking bench for addr_counter_stage: directed scenarios plus randomized run
// against an arithmetic reference model; two instances cascaded through RCO -> ENT.
module tb_addr_counter_stage;

    localparam int W = 16;
    localparam int N = W / 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         sclr_n, load_n, enp, ent, ud;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [N-1:0] nibco;
    logic         rco;

    logic         sclr1_n, load1_n, enp1, ud1;
    logic [W-1:0] d1;
    logic [W-1:0] q1;
    logic [N-1:0] nibco1;
    logic         rco1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] m_q;
    logic [W-1:0] m_q1;

    addr_counter_stage #(.WIDTH(W)) u0 (
        .CLK(clk), .CLR_N(rst_n), .SCLR_N(sclr_n), .LOAD_N(load_n),
        .ENP(enp), .ENT(ent),
`ifdef ADDR_COUNTER_UPDOWN_EN
        .U_D(ud),
`endif
        .D(d), .Q(q), .NIB_CO(nibco), .RCO(rco)
    );

    addr_counter_stage #(.WIDTH(W)) u1 (
        .CLK(clk), .CLR_N(rst_n), .SCLR_N(sclr1_n), .LOAD_N(load1_n),
        .ENP(enp1), .ENT(rco),
`ifdef ADDR_COUNTER_UPDOWN_EN
        .U_D(ud1),
`endif
        .D(d1), .Q(q1), .NIB_CO(nibco1), .RCO(rco1)
    );

    // Reference model: the counter as a plain integer modulo 2^W.
    function automatic logic [W-1:0] m_next(input logic [W-1:0] cur, input logic s_n, input logic l_n,
                                            input logic p, input logic t, input logic up,
                                            input logic [W-1:0] dd);
        int unsigned v;
        v = int'(cur);
        if (!s_n)         v = 0;
        else if (!l_n)    v = int'(dd);
        else if (p && t)  v = up ? (v + 1) % (1 << W) : (v + (1 << W) - 1) % (1 << W);
        return v[W-1:0];
    endfunction

    function automatic logic m_rco(input logic [W-1:0] cur, input logic t, input logic up);
        int unsigned v;
        v = int'(cur);
        return t && (up ? (v == (1 << W) - 1) : (v == 0));
    endfunction

    function automatic logic [N-1:0] m_nibco(input logic [W-1:0] cur, input logic t, input logic up);
        logic [N-1:0] r;
        int unsigned span, low;
        for (int i = 0; i < N; i++) begin
            span = 1 << (4 * (i + 1));
            low  = int'(cur) % span;
            r[i] = t && (up ? (low == span - 1) : (low == 0));
        end
        return r;
    endfunction

    task automatic tick();
        logic rco_pre;
        rco_pre = m_rco(m_q, ent, ud);
        @(posedge clk);
        m_q1 = m_next(m_q1, sclr1_n, load1_n, enp1, rco_pre, ud1, d1);
        m_q  = m_next(m_q, sclr_n, load_n, enp, ent, ud, d);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sclr_n = 1'b1; load_n = 1'b1; enp = 1'b0; ent = 1'b1; ud = 1'b1; d = '0;
        sclr1_n = 1'b1; load1_n = 1'b1; enp1 = 1'b0; ud1 = 1'b1; d1 = '0;
        m_q = '0; m_q1 = '0;
        #12;
        n_checks++; if (q !== 16'h0000) begin n_fail++; $display("FAIL reset_q: got %h expected 0000", q); end
        n_checks++; if (nibco !== 4'b0000) begin n_fail++; $display("FAIL reset_nibco: got %b expected 0000", nibco); end
        n_checks++; if (rco !== 1'b0) begin n_fail++; $display("FAIL reset_rco: got %b expected 0", rco); end
        n_checks++; if (q1 !== 16'h0000) begin n_fail++; $display("FAIL reset_q1: got %h expected 0000", q1); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        $display("test_reset: q=%h nibco=%b rco=%b", q, nibco, rco);
    endtask

    task automatic test_load_count();
        load_n = 1'b0; enp = 1'b1; ent = 1'b1; d = 16'hFFFE;
        tick();
        n_checks++; if (q !== 16'hFFFE) begin n_fail++; $display("FAIL load_q: got %h expected FFFE", q); end
        load_n = 1'b1;
        tick();
        n_checks++; if (q !== 16'hFFFF) begin n_fail++; $display("FAIL count_q: got %h expected FFFF", q); end
        n_checks++; if (rco !== 1'b1) begin n_fail++; $display("FAIL count_rco: got %b expected 1", rco); end
        n_checks++; if (nibco !== 4'b1111) begin n_fail++; $display("FAIL count_nibco: got %b expected 1111", nibco); end
        tick();
        n_checks++; if (q !== 16'h0000) begin n_fail++; $display("FAIL wrap_q: got %h expected 0000", q); end
        n_checks++; if (rco !== 1'b0) begin n_fail++; $display("FAIL wrap_rco: got %b expected 0", rco); end
        enp = 1'b0;
        $display("test_load_count: q=%h rco=%b", q, rco);
    endtask

    task automatic test_gating();
        load_n = 1'b0; d = 16'h00FF;
        tick();
        load_n = 1'b1; enp = 1'b0; ent = 1'b1;
        tick();
        n_checks++; if (q !== 16'h00FF) begin n_fail++; $display("FAIL enp_hold_q: got %h expected 00FF", q); end
        n_checks++; if (nibco !== 4'b0011) begin n_fail++; $display("FAIL enp_nibco: got %b expected 0011", nibco); end
        n_checks++; if (rco !== 1'b0) begin n_fail++; $display("FAIL enp_rco: got %b expected 0", rco); end
        ent = 1'b0; enp = 1'b1;
        #1;
        n_checks++; if (nibco !== 4'b0000) begin n_fail++; $display("FAIL ent_nibco: got %b expected 0000", nibco); end
        n_checks++; if (rco !== 1'b0) begin n_fail++; $display("FAIL ent_rco: got %b expected 0", rco); end
        tick();
        n_checks++; if (q !== 16'h00FF) begin n_fail++; $display("FAIL ent_hold_q: got %h expected 00FF", q); end
        enp = 1'b0; ent = 1'b1;
        $display("test_gating: q=%h nibco=%b", q, nibco);
    endtask

    task automatic test_priority();
        sclr_n = 1'b0; load_n = 1'b0; d = 16'hABCD; enp = 1'b1; ent = 1'b1;
        tick();
        n_checks++; if (q !== 16'h0000) begin n_fail++; $display("FAIL prio_q: got %h expected 0000", q); end
        sclr_n = 1'b1; load_n = 1'b1; enp = 1'b0;
        $display("test_priority: q=%h", q);
    endtask

    task automatic test_async_reset();
        load_n = 1'b0; d = 16'h1234; ent = 1'b1;
        tick();
        load_n = 1'b1;
        n_checks++; if (q !== 16'h1234) begin n_fail++; $display("FAIL areset_pre_q: got %h expected 1234", q); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (q !== 16'h0000) begin n_fail++; $display("FAIL areset_q: got %h expected 0000", q); end
        n_checks++; if (rco !== 1'b0) begin n_fail++; $display("FAIL areset_rco: got %b expected 0", rco); end
        m_q = '0; m_q1 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("test_async_reset: q=%h rco=%b", q, rco);
    endtask

    task automatic test_cascade();
        load_n = 1'b0; d = 16'hFFFF; load1_n = 1'b0; d1 = 16'h0000;
        enp = 1'b1; ent = 1'b1; enp1 = 1'b1;
        tick();
        load_n = 1'b1; load1_n = 1'b1;
        tick();
        n_checks++; if (q !== 16'h0000) begin n_fail++; $display("FAIL cascade_low: got %h expected 0000", q); end
        n_checks++; if (q1 !== 16'h0001) begin n_fail++; $display("FAIL cascade_high: got %h expected 0001", q1); end
        enp = 1'b0; enp1 = 1'b0;
        $display("test_cascade: low=%h high=%h", q, q1);
    endtask

`ifdef ADDR_COUNTER_UPDOWN_EN
    task automatic test_down();
        load_n = 1'b0; d = 16'h0001; ud = 1'b1;
        tick();
        load_n = 1'b1; ud = 1'b0; enp = 1'b1; ent = 1'b1;
        tick();
        n_checks++; if (q !== 16'h0000) begin n_fail++; $display("FAIL down_q0: got %h expected 0000", q); end
        n_checks++; if (rco !== 1'b1) begin n_fail++; $display("FAIL down_rco0: got %b expected 1", rco); end
        n_checks++; if (nibco !== 4'b1111) begin n_fail++; $display("FAIL down_nibco0: got %b expected 1111", nibco); end
        tick();
        n_checks++; if (q !== 16'hFFFF) begin n_fail++; $display("FAIL down_qF: got %h expected FFFF", q); end
        n_checks++; if (rco !== 1'b0) begin n_fail++; $display("FAIL down_rcoF: got %b expected 0", rco); end
        enp = 1'b0; ud = 1'b1;
        $display("test_down: q=%h rco=%b", q, rco);
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] picks [4];
        picks[0] = 16'hFFFE; picks[1] = 16'h00FE; picks[2] = 16'h0001; picks[3] = 16'h0FFF;
        for (int it = 0; it < 400; it++) begin
            sclr_n  = ($urandom_range(0, 15) != 0);
            load_n  = ($urandom_range(0, 7) != 0);
            enp     = ($urandom_range(0, 3) != 0);
            ent     = ($urandom_range(0, 3) != 0);
            d       = ($urandom_range(0, 1) == 0) ? picks[$urandom_range(0, 3)] : W'($urandom);
            sclr1_n = ($urandom_range(0, 15) != 0);
            load1_n = ($urandom_range(0, 7) != 0);
            enp1    = ($urandom_range(0, 3) != 0);
            d1      = ($urandom_range(0, 1) == 0) ? picks[$urandom_range(0, 3)] : W'($urandom);
`ifdef ADDR_COUNTER_UPDOWN_EN
            ud      = ($urandom_range(0, 2) != 0);
            ud1     = ($urandom_range(0, 2) != 0);
`endif
            #1;
            n_checks++; if (q !== m_q) begin n_fail++; $display("FAIL rand_q[%0d]: got %h expected %h", it, q, m_q); end
            n_checks++; if (q1 !== m_q1) begin n_fail++; $display("FAIL rand_q1[%0d]: got %h expected %h", it, q1, m_q1); end
            n_checks++; if (rco !== m_rco(m_q, ent, ud)) begin n_fail++; $display("FAIL rand_rco[%0d]: got %b expected %b", it, rco, m_rco(m_q, ent, ud)); end
            n_checks++; if (nibco !== m_nibco(m_q, ent, ud)) begin n_fail++; $display("FAIL rand_nibco[%0d]: got %b expected %b", it, nibco, m_nibco(m_q, ent, ud)); end
            n_checks++; if (rco1 !== m_rco(m_q1, m_rco(m_q, ent, ud), ud1)) begin n_fail++; $display("FAIL rand_rco1[%0d]: got %b", it, rco1); end
            n_checks++; if (nibco1 !== m_nibco(m_q1, m_rco(m_q, ent, ud), ud1)) begin n_fail++; $display("FAIL rand_nibco1[%0d]: got %b", it, nibco1); end
            tick();
        end
        ud = 1'b1; ud1 = 1'b1;
        $display("test_random: final q=%h q1=%h", q, q1);
    endtask

    initial begin
        test_reset();
        test_load_count();
        test_gating();
        test_priority();
        test_async_reset();
        test_cascade();
`ifdef ADDR_COUNTER_UPDOWN_EN
        test_down();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
